// File: rtl/data_memory_responder.sv
// Data-memory slave: one load/store at a time over valid/ready, fixed access latency,
// registered response with error flag. Word array with byte-lane write enables.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    input  logic [3:0]  req_byte_enable,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic                  commit;
    logic                  addr_err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [31:0] mem [DEPTH];

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
    assign mem_we   = commit && wr_q && !addr_err;

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = (state_q == RESPOND);
    assign resp_read_data = rdata_q;
    assign resp_error     = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_address;
                    wdata_d = req_write_data;
                    be_d    = req_byte_enable;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access commits on the same edge that registers the response.
                    commit  = 1'b1;
                    err_d   = addr_err;
                    rdata_d = (addr_err || wr_q) ? 32'd0 : mem[word_idx];
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields need no reset; they are only consumed after acceptance.
    always_ff @(posedge clock) begin
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Storage survives reset; an aborted transaction never reaches commit.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder, three latency variants
// (2, 1, 15) sharing clock and reset, each checked against a word-array model.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  req_valid, req_write, resp_ready;
    logic [31:0] req_address     [3];
    logic [31:0] req_write_data  [3];
    logic [3:0]  req_byte_enable [3];
    logic [2:0]  req_ready, resp_valid, resp_error;
    logic [31:0] resp_read_data  [3];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [3][1024];

    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            data_memory_responder #(
                .ADDR_WIDTH(10),
                .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
            ) dut (
                .clock          (clock),
                .clear          (clear),
                .req_valid      (req_valid[g]),
                .req_ready      (req_ready[g]),
                .req_write      (req_write[g]),
                .req_address    (req_address[g]),
                .req_write_data (req_write_data[g]),
                .req_byte_enable(req_byte_enable[g]),
                .resp_valid     (resp_valid[g]),
                .resp_ready     (resp_ready[g]),
                .resp_read_data (resp_read_data[g]),
                .resp_error     (resp_error[g])
            );
        end
    endgenerate

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk({tag, "_req_ready"},  32'(req_ready[k]),  32'd1);
            chk({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'd0);
            chk({tag, "_resp_data"},  resp_read_data[k],  32'd0);
            chk({tag, "_resp_error"}, 32'(resp_error[k]), 32'd0);
        end
    endtask

    task automatic scramble(input int k);
        req_write[k]       = 1'($urandom);
        req_address[k]     = $urandom;
        req_write_data[k]  = $urandom;
        req_byte_enable[k] = 4'($urandom);
    endtask

    // One complete transaction; hold = cycles resp_ready stays low in RESPOND.
    task automatic txn(input int k, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input int hold);
        int          lat;
        logic        exp_e;
        logic [31:0] exp_d;
        @(negedge clock);
        chk("idle_req_ready", 32'(req_ready[k]), 32'd1);
        req_valid[k]       = 1'b1;
        req_write[k]       = wr;
        req_address[k]     = addr;
        req_write_data[k]  = data;
        req_byte_enable[k] = be;
        resp_ready[k]      = (hold == 0);
        @(posedge clock);
        #1;
        req_valid[k] = 1'b0;
        scramble(k);
        chk("accept_req_ready", 32'(req_ready[k]), 32'd0);
        lat = 0;
        while (resp_valid[k] !== 1'b1 && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_of(k)));
        exp_e = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
        exp_d = (exp_e || wr) ? 32'd0 : mem_m[k][addr[11:2]];
        chk("resp_data",  resp_read_data[k],  exp_d);
        chk("resp_error", 32'(resp_error[k]), 32'(exp_e));
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clock);
                req_valid[k] = 1'b1;
                scramble(k);
                @(posedge clock);
                #1;
                chk("stall_valid", 32'(resp_valid[k]), 32'd1);
                chk("stall_data",  resp_read_data[k],  exp_d);
                chk("stall_error", 32'(resp_error[k]), 32'(exp_e));
                chk("stall_ready", 32'(req_ready[k]),  32'd0);
            end
            @(negedge clock);
            req_valid[k]  = 1'b0;
            resp_ready[k] = 1'b1;
        end
        @(posedge clock);
        #1;
        chk("hs_req_ready",  32'(req_ready[k]),  32'd1);
        chk("hs_resp_valid", 32'(resp_valid[k]), 32'd0);
        resp_ready[k] = 1'b0;
        if (wr && !exp_e) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_m[k][addr[11:2]][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic run_random(input int k, input int n, input int max_hold);
        logic [31:0] pool [8];
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 8; i++) begin
            pool[i] = {20'd0, 10'($urandom), 2'b00};
            txn(k, 1'b1, pool[i], $urandom, 4'hF, 0);
        end
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 3);
            a  = pool[$urandom_range(0, 7)];
            case (op)
                0: txn(k, 1'b1, a, $urandom, 4'($urandom), $urandom_range(0, max_hold));
                3: begin
                    if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(1, 3));
                    else a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
                    txn(k, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, max_hold));
                end
                default: txn(k, 1'b0, a, $urandom, 4'($urandom), $urandom_range(0, max_hold));
            endcase
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid  = '0;
        req_write  = '0;
        resp_ready = '0;
        for (int k = 0; k < 3; k++) begin
            req_address[k]     = '0;
            req_write_data[k]  = '0;
            req_byte_enable[k] = '0;
        end
        #12;
        check_reset("por");
        @(negedge clock);
        clear = 1'b1;

        // Store/load, lane masking, no-op store
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("model_deadbeef", mem_m[0][4], 32'hDEADBEEF);
        txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
        txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        chk("model_deadbeaa", mem_m[0][4], 32'hDEADBEAA);

        // Error accesses
        txn(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0);
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h1000, 32'h11111111, 4'hF, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);

        // Response stall
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);

        // Reset during WAIT discards the store
        txn(0, 1'b1, 32'h20, 32'hCAFE0020, 4'hF, 0);
        @(negedge clock);
        req_valid[0]       = 1'b1;
        req_write[0]       = 1'b1;
        req_address[0]     = 32'h20;
        req_write_data[0]  = 32'h12345678;
        req_byte_enable[0] = 4'hF;
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        chk("abort_accepted", 32'(req_ready[0]), 32'd0);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check_reset("abort");
        @(posedge clock);
        #1;
        check_reset("abort_held");
        @(negedge clock);
        clear = 1'b1;
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        // Randomized traffic with stalls on LATENCY=2
        run_random(0, 40, 3);

        // Back-to-back traffic, resp_ready high, LATENCY=1 and 15
        run_random(1, 24, 0);
        run_random(2, 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
